cargador_memorias: RTL
======================

CARGADOR_MEMORIAS -- requirements
Module: cargador_memorias

Interface
REQ-001 Parameter QUEUE_QUANTITY, default 4: number of queues and number of pesos entries.
REQ-002 Parameter MAX_WEIGHT, default 64: weight range; weight field width WW = $clog2(MAX_WEIGHT) = 6.
REQ-003 Parameter TABLE_SIZE, default 8: arbitration table entries.
REQ-004 Parameter TIPOS_ROUND_ROBIN, default 3: round-robin modes; selector width RW = $clog2(TIPOS_ROUND_ROBIN) = 2.
REQ-005 Parameter HEADER, default 8'hA5: frame start byte.
REQ-006 Clock and reset: one clock, clk; reset rst, synchronous and active-low.
REQ-007 clk  input  1  clock; all logic on its rising edge.
REQ-008 rst  input  1  synchronous active-low reset.
REQ-009 enb  input  1  block enable; when 0, no byte is accepted and state holds.
REQ-010 abortar  input  1  drops the frame in progress.
REQ-011 data_in  input  8  configuration byte stream.
REQ-012 valid_in  input  1  data_in valid.
REQ-013 ready_out  output  1  byte accepted on an edge where valid_in && ready_out.
REQ-014 iniciar  output  1  one-cycle commit strobe to the configuration memory.
REQ-015 seleccion_roundRobin_out  output  RW  committed round-robin mode.
REQ-016 pesos_out  output  QUEUE_QUANTITY*WW  committed queue weights.
REQ-017 pesosArbitraje_out  output  TABLE_SIZE*WW  committed table weights.
REQ-018 selecciones_out  output  TABLE_SIZE*$clog2(QUEUE_QUANTITY)  committed table queue selections.
REQ-019 error_trama  output  1  one-cycle pulse when a frame is rejected.
REQ-020 tramas_ok  output  8  count of committed frames, wraps 255->0.

Function
REQ-021 Frame: HEADER, 1 RR byte, QUEUE_QUANTITY pesos bytes, TABLE_SIZE arbitraje bytes, TABLE_SIZE selecciones bytes (21 payload bytes at defaults).
REQ-022 FSM states: IDLE, RR, PESOS, ARB, SEL (plus CHK per REQ-034); index counter walks entries within PESOS/ARB/SEL.
REQ-023 IDLE: byte == HEADER -> RR; any other byte discarded, stay IDLE.
REQ-024 Each field uses the low bits of its byte (RW, WW or $clog2(QUEUE_QUANTITY)); upper bits ignored.
REQ-025 Entry i received i-th occupies bits [i*W +: W]; payload assembled in staging registers, never in outputs.
REQ-026 ready_out = enb && rst in every state; valid_in without ready_out is not consumed.
REQ-027 On the edge accepting the last frame byte with no error: staging copied to all four config outputs, iniciar=1 for exactly the following cycle, tramas_ok+1, FSM -> IDLE.
REQ-028 Config outputs change only on a commit edge; they are stable while iniciar=1 and hold until the next commit.
REQ-029 RR field value >= TIPOS_ROUND_ROBIN: frame rejected at end of frame (no commit), error_trama pulses one cycle, outputs unchanged.
REQ-030 abortar=1: FSM -> IDLE on that edge, staging discarded, byte presented that cycle not consumed, no error_trama; abortar has priority over data.
REQ-031 HEADER value inside a payload is data, not a restart.
REQ-032 Back-to-back frames: HEADER of the next frame is accepted in the cycle where iniciar=1.

Reset
REQ-033 rst=0 at an edge: FSM IDLE, index 0, staging 0, all outputs 0 (ready_out 0 while rst=0), tramas_ok 0; a partial frame is lost with no iniciar or error_trama.

Configuration
REQ-034 Macro CARGADOR_CHECKSUM_EN defined: CHK state follows SEL, one extra byte equal to XOR of all payload bytes (HEADER excluded); mismatch -> reject as REQ-029; undefined: no CHK state, frame ends after last selecciones byte.

Verification
REQ-035 Frame A5,02,01,02,03,04,8x3F,00,01,02,03,00,01,02,03 (+06 if macro) -> iniciar one cycle, rr=2, pesos_out=24'h103081, pesosArbitraje_out=48'hFFFFFFFFFFFF, selecciones_out=16'hE4E4, tramas_ok=1.
REQ-036 Bytes 00,FF then same frame -> leading bytes discarded, identical commit.
REQ-037 Frame with RR byte 03 -> error_trama one cycle, no iniciar, outputs stay at previous values.
REQ-038 abortar after 5 payload bytes, then full frame -> single commit of second frame only.
REQ-039 rst=0 mid-frame, enb toggled low mid-frame, valid_in gaps -> no spurious commit; ready_out=0 whenever enb=0; frame resumes correctly after enb returns to 1.
REQ-040 With macro: checksum 07 instead of 06 -> error_trama, no commit.

Source files
------------

// File: rtl/cargador_memorias.sv
// Configuration frame loader: parses HEADER-delimited byte frames into staging registers and
// commits them atomically to the configuration outputs. Define CARGADOR_CHECKSUM_EN for an XOR trailer byte.
module cargador_memorias #(
  parameter int          QUEUE_QUANTITY    = 4,
  parameter int          MAX_WEIGHT        = 64,
  parameter int          TABLE_SIZE        = 8,
  parameter int          TIPOS_ROUND_ROBIN = 3,
  parameter logic [7:0]  HEADER            = 8'hA5,
  localparam int         WW                = $clog2(MAX_WEIGHT),
  localparam int         RW                = $clog2(TIPOS_ROUND_ROBIN),
  localparam int         SW                = $clog2(QUEUE_QUANTITY)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enb,
  input  logic                         abortar,
  input  logic [7:0]                   data_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic                         iniciar,
  output logic [RW-1:0]                seleccion_roundRobin_out,
  output logic [QUEUE_QUANTITY*WW-1:0] pesos_out,
  output logic [TABLE_SIZE*WW-1:0]     pesosArbitraje_out,
  output logic [TABLE_SIZE*SW-1:0]     selecciones_out,
  output logic                         error_trama,
  output logic [7:0]                   tramas_ok
);

  localparam int MaxEntries = (TABLE_SIZE > QUEUE_QUANTITY) ? TABLE_SIZE : QUEUE_QUANTITY;
  localparam int IW         = (MaxEntries > 1) ? $clog2(MaxEntries) : 1;

  typedef enum logic [2:0] {StIdle, StRr, StPesos, StArb, StSel, StChk} state_e;

  state_e                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [RW-1:0]               rr_q, rr_d;
  logic [QUEUE_QUANTITY*WW-1:0] pesos_q, pesos_d;
  logic [TABLE_SIZE*WW-1:0]    arb_q, arb_d;
  logic [TABLE_SIZE*SW-1:0]    sel_q, sel_d;
  logic                        take, abort, end_frame, chk_bad, commit, reject;
`ifdef CARGADOR_CHECKSUM_EN
  logic [7:0]                  chk_q, chk_d;
`endif

  assign ready_out = enb & rst;
  // abortar wins over data: the byte presented on an abort edge is not consumed
  assign abort     = enb & abortar;
  assign take      = ready_out & valid_in & ~abortar;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_d      = rr_q;
    pesos_d   = pesos_q;
    arb_d     = arb_q;
    sel_d     = sel_q;
    end_frame = 1'b0;
    chk_bad   = 1'b0;
`ifdef CARGADOR_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    if (abort) begin
      state_d = StIdle;
      idx_d   = '0;
      rr_d    = '0;
      pesos_d = '0;
      arb_d   = '0;
      sel_d   = '0;
`ifdef CARGADOR_CHECKSUM_EN
      chk_d   = '0;
`endif
    end else if (take) begin
`ifdef CARGADOR_CHECKSUM_EN
      if (state_q != StIdle) chk_d = chk_q ^ data_in;
`endif
      case (state_q)
        StIdle: begin
          if (data_in == HEADER) begin
            state_d = StRr;
            idx_d   = '0;
`ifdef CARGADOR_CHECKSUM_EN
            chk_d   = '0;
`endif
          end
        end
        StRr: begin
          rr_d    = data_in[RW-1:0];
          idx_d   = '0;
          state_d = StPesos;
        end
        StPesos: begin
          pesos_d[idx_q*WW +: WW] = data_in[WW-1:0];
          if (idx_q == IW'(QUEUE_QUANTITY - 1)) begin
            idx_d   = '0;
            state_d = StArb;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        StArb: begin
          arb_d[idx_q*WW +: WW] = data_in[WW-1:0];
          if (idx_q == IW'(TABLE_SIZE - 1)) begin
            idx_d   = '0;
            state_d = StSel;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        StSel: begin
          sel_d[idx_q*SW +: SW] = data_in[SW-1:0];
          if (idx_q == IW'(TABLE_SIZE - 1)) begin
            idx_d = '0;
`ifdef CARGADOR_CHECKSUM_EN
            state_d = StChk;
`else
            end_frame = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
`ifdef CARGADOR_CHECKSUM_EN
        StChk: begin
          end_frame = 1'b1;
          chk_bad   = (data_in != chk_q);
        end
`endif
        default: state_d = StIdle;
      endcase
      if (end_frame) begin
        state_d = StIdle;
        idx_d   = '0;
      end
    end
  end

  assign reject = end_frame & ((32'(rr_q) >= 32'(TIPOS_ROUND_ROBIN)) | chk_bad);
  assign commit = end_frame & ~reject;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q                  <= StIdle;
      idx_q                    <= '0;
      rr_q                     <= '0;
      pesos_q                  <= '0;
      arb_q                    <= '0;
      sel_q                    <= '0;
`ifdef CARGADOR_CHECKSUM_EN
      chk_q                    <= '0;
`endif
      iniciar                  <= 1'b0;
      error_trama              <= 1'b0;
      seleccion_roundRobin_out <= '0;
      pesos_out                <= '0;
      pesosArbitraje_out       <= '0;
      selecciones_out          <= '0;
      tramas_ok                <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      pesos_q     <= pesos_d;
      arb_q       <= arb_d;
      sel_q       <= sel_d;
`ifdef CARGADOR_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
      iniciar     <= commit;
      error_trama <= reject;
      // sel_d carries the final selecciones byte when it is the last byte of the frame
      if (commit) begin
        seleccion_roundRobin_out <= rr_q;
        pesos_out                <= pesos_q;
        pesosArbitraje_out       <= arb_q;
        selecciones_out          <= sel_d;
        tramas_ok                <= tramas_ok + 8'd1;
      end
    end
  end

endmodule
